// File: rtl/pulse_gate_driver.sv
// pulse_gate_driver: turns level operand bits into a/b pulses followed by a gate clock pulse,
// with setup/hold spacing fixed by a phase counter. Optional output capture: PULSE_DRV_CAPTURE_EN.
module pulse_gate_driver #(
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned T_SETUP = 10,
  parameter int unsigned T_HOLD  = 5,
  parameter int unsigned T_OUT   = 20,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_a,
  input  logic in_b,
  output logic a_pulse,
  output logic b_pulse,
  output logic clk_pulse,
  output logic busy,
  input  logic out_pulse,
  output logic res_valid,
  output logic res_bit,
  output logic res_err
);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_SETUP, S_CLK, S_HOLD} state_t;

`ifdef PULSE_DRV_CAPTURE_EN
  localparam bit CAPTURE = 1'b1;
`else
  localparam bit CAPTURE = 1'b0;
`endif
  localparam int unsigned HOLD_LEN = CAPTURE ? T_OUT : T_HOLD;
  localparam logic [CNT_W-1:0] L_PULSE = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(T_SETUP - PULSE_W);
  localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(HOLD_LEN);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_opa, r_opb;
  logic             r_in_ready, r_busy, r_a_pulse, r_b_pulse, r_clk_pulse;
  logic             w_accept, w_last, w_opa, w_opb;
  logic             w_in_ready, w_busy, w_a_pulse, w_b_pulse, w_clk_pulse;

  assign w_accept = in_valid && r_in_ready && (r_state == S_IDLE);
  assign w_last   = (r_cnt == CNT_W'(1));
  assign w_opa    = w_accept ? in_a : r_opa;
  assign w_opb    = w_accept ? in_b : r_opb;

  // Outputs are registered from the next state so every pin comes straight off a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_opa       <= 1'b0;
      r_opb       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_a_pulse   <= 1'b0;
      r_b_pulse   <= 1'b0;
      r_clk_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_opa       <= w_opa;
      r_opb       <= w_opb;
      r_in_ready  <= w_in_ready;
      r_busy      <= w_busy;
      r_a_pulse   <= w_a_pulse;
      r_b_pulse   <= w_b_pulse;
      r_clk_pulse <= w_clk_pulse;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt - CNT_W'(1);
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_accept) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = L_PULSE;
        end
      end
      S_DATA:  if (w_last) begin w_state_nxt = S_SETUP; w_cnt_nxt = L_SETUP; end
      S_SETUP: if (w_last) begin w_state_nxt = S_CLK;   w_cnt_nxt = L_PULSE; end
      S_CLK:   if (w_last) begin w_state_nxt = S_HOLD;  w_cnt_nxt = L_HOLD;  end
      S_HOLD:  if (w_last) begin w_state_nxt = S_IDLE;  w_cnt_nxt = '0;      end
      default: begin w_state_nxt = S_IDLE; w_cnt_nxt = '0; end
    endcase
  end

  always_comb begin
    w_in_ready  = (w_state_nxt == S_IDLE);
    w_busy      = (w_state_nxt != S_IDLE);
    w_a_pulse   = (w_state_nxt == S_DATA) && w_opa;
    w_b_pulse   = (w_state_nxt == S_DATA) && w_opb;
    w_clk_pulse = (w_state_nxt == S_CLK);
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign a_pulse   = r_a_pulse;
  assign b_pulse   = r_b_pulse;
  assign clk_pulse = r_clk_pulse;

`ifdef PULSE_DRV_CAPTURE_EN
  logic       r_any, r_prev, r_rv, r_rb, r_re;
  logic [1:0] r_rises, w_rises_nxt;
  logic       w_window, w_done;

  // Sample window spans CLK and HOLD; rising-edge count saturates at 2.
  assign w_window    = (r_state == S_CLK) || (r_state == S_HOLD);
  assign w_done      = (r_state == S_HOLD) && w_last;
  assign w_rises_nxt = (out_pulse && !r_prev && (r_rises != 2'd2)) ? r_rises + 2'd1 : r_rises;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_any   <= 1'b0;
      r_prev  <= 1'b0;
      r_rises <= '0;
      r_rv    <= 1'b0;
      r_rb    <= 1'b0;
      r_re    <= 1'b0;
    end else begin
      r_rv <= w_done;
      if (w_accept) begin
        r_any   <= 1'b0;
        r_prev  <= 1'b0;
        r_rises <= '0;
      end else if (w_window) begin
        r_any   <= r_any || out_pulse;
        r_prev  <= out_pulse;
        r_rises <= w_rises_nxt;
      end
      if (w_done) begin
        r_rb <= r_any || out_pulse;
        r_re <= (w_rises_nxt == 2'd2);
      end
    end
  end

  assign res_valid = r_rv;
  assign res_bit   = r_rb;
  assign res_err   = r_re;
`else
  logic w_unused_out_pulse;
  assign w_unused_out_pulse = out_pulse;
  assign res_valid = 1'b0;
  assign res_bit   = 1'b0;
  assign res_err   = 1'b0;
`endif

endmodule

// File: doc/pulse_gate_driver.md
# pulse_gate_driver

Synthesizable stimulus transmitter for the pulse-logic gate library. It converts level-valid operand bits into input pulses followed by a clock pulse, with setup and hold spacing enforced by construction, so the downstream gate never sees a timing violation. It sits between a test sequencer or control FSM and a two-input clocked pulse gate such as `xor_gate`. Optionally, it captures the gate's returned output pulse and reports it as a level result.

## Interface
Parameters:
- `PULSE_W`, 2: width of every emitted pulse, in cycles; must be ≥1.
- `T_SETUP`, 10: cycles from a/b pulse rise to clock pulse rise; must be > `PULSE_W`.
- `T_HOLD`, 5: idle cycles after the clock pulse falls before the next accept; must be ≥1.
- `T_OUT`, 20: post-clock capture phase length; used only with capture; must be ≥ `T_HOLD`.
- `CNT_W`, 8: phase counter width; must hold max(`T_SETUP`, `T_OUT`).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair offered.
- `in_ready` out 1: driver can accept.
- `in_a` in 1: operand A.
- `in_b` in 1: operand B.
- `a_pulse` out 1: pulse to gate input a.
- `b_pulse` out 1: pulse to gate input b.
- `clk_pulse` out 1: pulse to gate clk.
- `busy` out 1: high whenever state is not IDLE.
- `out_pulse` in 1: gate output (capture build only).
- `res_valid` out 1: result strobe (capture build only).
- `res_bit` out 1: captured output value (capture build only).
- `res_err` out 1: more than one output pulse seen (capture build only).

## Operation
- FSM states: IDLE → DATA → SETUP → CLK → HOLD → IDLE.
- IDLE:
  - `in_ready`=1.
  - Handshake completes on `in_valid & in_ready` at a rising edge.
  - `in_a` and `in_b` are registered at that edge.
- DATA, `PULSE_W` cycles: `a_pulse`=registered A and `b_pulse`=registered B.
- SETUP, `T_SETUP-PULSE_W` cycles: all pulse outputs low.
- CLK, `PULSE_W` cycles: `clk_pulse`=1. This is emitted even when A=B=0, so the gate state is still read and cleared.
- HOLD, `T_HOLD` cycles: all pulse outputs low. Then return to IDLE.
- `in_ready` is 0 in every state except IDLE. `in_valid` is ignored outside IDLE.
- All outputs are registered, glitch-free, and driven directly from state or counter flops.
- A single down-counter of `CNT_W` bits is reloaded on each state entry. A state is left when the counter reaches 1.

## Timing
- Reset values: `in_ready`=0 while `rst_n`=0 and 1 in the first cycle after release. `busy`, all pulse outputs, `res_valid`, `res_bit` and `res_err` are 0.
- Accept at edge 0 gives:
  - a/b high in cycles 1..`PULSE_W`.
  - `clk_pulse` high in cycles `T_SETUP+1`..`T_SETUP+PULSE_W`.
  - `in_ready` high again in cycle `T_SETUP+PULSE_W+T_HOLD+1`.
- Sustained throughput: one transaction per `T_SETUP+PULSE_W+T_HOLD+1` cycles.
- Reset asserted mid-transaction: all outputs go to 0 asynchronously, the FSM returns to IDLE, and any pending result is discarded with no `res_valid`.
- `in_valid` dropping after the accept has no effect. The transaction always completes.

## Configuration
- Macro: `PULSE_DRV_CAPTURE_EN`.
- Defined:
  - HOLD lasts `T_OUT` cycles instead of `T_HOLD`.
  - `out_pulse` is sampled synchronously from the first CLK cycle through the last HOLD cycle.
  - `res_bit`=1 if any sample is high.
  - `res_err`=1 if two or more rising edges are seen.
  - `res_valid` pulses for 1 cycle in the first IDLE cycle. `res_bit` and `res_err` are held until the next `res_valid`.
- Undefined:
  - The `out_pulse` port is present but unused.
  - `res_valid`, `res_bit` and `res_err` are tied to 0.
  - HOLD lasts `T_HOLD` cycles.

## Test plan
All scenarios use the default parameters.
- Reset release, then `in_valid`=1 with A=1, B=0, accepted at edge 0 → `a_pulse` high in cycles 1–2, `b_pulse` stays 0, `clk_pulse` high in cycles 11–12, `in_ready` returns in cycle 18.
- A=0, B=0 → no data pulses; `clk_pulse` still high in cycles 11–12.
- `in_valid` held high for 3 transactions → accepts at edges 0, 18 and 36; `busy` is low only at those cycles.
- `rst_n` pulsed low at cycle 5 of a transaction → all outputs 0 immediately; `in_ready`=1 on the first cycle after release; the next accept gives normal timing.
- `PULSE_DRV_CAPTURE_EN`, A=1, B=0, bench drives `out_pulse` high in cycles 16–17 → `res_valid` in cycle 33 with `res_bit`=1 and `res_err`=0.
- `PULSE_DRV_CAPTURE_EN`, `out_pulse` high in cycles 14 and 20 → `res_bit`=1 and `res_err`=1. With no `out_pulse` → `res_bit`=0.
